// File: rtl/fb_draw_arbiter.sv
// Round-robin rectangle-fill arbiter driving the frame buffer write port.
// Each accepted command is clipped to the screen and streamed as one pixel write per clock.
module fb_draw_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SCR_W   = 640,
  parameter int SCR_H   = 480,
  parameter int ADDR_W  = 19
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NUM_REQ-1:0]    REQ_VALID,
  output logic [NUM_REQ-1:0]    REQ_READY,
  input  logic [NUM_REQ*10-1:0] REQ_X,
  input  logic [NUM_REQ*9-1:0]  REQ_Y,
  input  logic [NUM_REQ*10-1:0] REQ_W,
  input  logic [NUM_REQ*9-1:0]  REQ_H,
  input  logic [NUM_REQ*24-1:0] REQ_COLOR,
  output logic [NUM_REQ-1:0]    REQ_DONE,
  output logic                  WRITE_EN,
  output logic [ADDR_W-1:0]     WRITE_ADDR,
  output logic [23:0]           WRITE_DATA,
  output logic                  BUSY,
  output logic [1:0]            DBG_STATE
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FILL, S_DONE} state_t;

  // Handshake: a command transfers on a rising CLK edge where REQ_VALID[i] && REQ_READY[i].
  state_t              r_state, w_next;
  logic [IDX_W-1:0]    r_last, r_owner, w_grant;
  logic                w_grant_vld, w_accept;
  int                  w_idx;
  logic [9:0]          r_x, r_w, r_cx;
  logic [8:0]          r_y, r_h, r_cy;
  logic [23:0]         r_color;
  logic [10:0]         r_xe, w_xsum, w_xe;
  logic [9:0]          r_ye, w_ysum, w_ye;
  logic [ADDR_W-1:0]   r_row_base, w_y_base;
  logic                w_empty, w_row_end, w_col_end, w_last_px;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [23:0]         r_data;
  logic [NUM_REQ-1:0]  r_done;

  // Search starts just after the last winner, so the previous owner ranks lowest.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_last) + 1 + k) % NUM_REQ;
      if (!w_grant_vld && REQ_VALID[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant     = IDX_W'(w_idx);
      end
    end
  end

  always_comb begin
    REQ_READY = '0;
    if (r_state == S_IDLE && w_grant_vld) REQ_READY[w_grant] = 1'b1;
  end

  assign w_accept  = (r_state == S_IDLE) && w_grant_vld;
  assign w_xsum    = {1'b0, r_x} + {1'b0, r_w};
  assign w_ysum    = {1'b0, r_y} + {1'b0, r_h};
  assign w_xe      = (w_xsum > 11'(SCR_W)) ? 11'(SCR_W) : w_xsum;
  assign w_ye      = (w_ysum > 10'(SCR_H)) ? 10'(SCR_H) : w_ysum;
  assign w_empty   = (r_w == '0) || (r_h == '0) ||
                     ({1'b0, r_x} >= 11'(SCR_W)) || ({1'b0, r_y} >= 10'(SCR_H));
  assign w_y_base  = (SCR_W == 640) ? ((ADDR_W'(r_y) << 9) + (ADDR_W'(r_y) << 7))
                                    : (ADDR_W'(r_y) * ADDR_W'(SCR_W));
  // r_cx/r_cy name the pixel currently presented on the write port.
  assign w_row_end = (({1'b0, r_cx} + 11'd1) == r_xe);
  assign w_col_end = (({1'b0, r_cy} + 10'd1) == r_ye);
  assign w_last_px = w_row_end && w_col_end;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_LOAD;
      S_LOAD:  w_next = w_empty ? S_DONE : S_FILL;
      S_FILL:  if (w_last_px) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_last     <= IDX_W'(NUM_REQ - 1);
      r_owner    <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_color    <= '0;
      r_xe       <= '0;
      r_ye       <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_row_base <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_done     <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_x     <= REQ_X[int'(w_grant)*10 +: 10];
          r_y     <= REQ_Y[int'(w_grant)*9 +: 9];
          r_w     <= REQ_W[int'(w_grant)*10 +: 10];
          r_h     <= REQ_H[int'(w_grant)*9 +: 9];
          r_color <= REQ_COLOR[int'(w_grant)*24 +: 24];
          r_owner <= w_grant;
          r_last  <= w_grant;
        end
        S_LOAD: begin
          r_xe <= w_xe;
          r_ye <= w_ye;
          if (w_empty) begin
            r_done <= NUM_REQ'(1) << r_owner;
          end else begin
            r_cx       <= r_x;
            r_cy       <= r_y;
            r_row_base <= w_y_base;
            r_we       <= 1'b1;
            r_addr     <= w_y_base + ADDR_W'(r_x);
            r_data     <= r_color;
          end
        end
        S_FILL: begin
          if (w_last_px) begin
            r_we   <= 1'b0;
            r_done <= NUM_REQ'(1) << r_owner;
          end else if (w_row_end) begin
            r_cx       <= r_x;
            r_cy       <= r_cy + 9'd1;
            r_row_base <= r_row_base + ADDR_W'(SCR_W);
            r_addr     <= r_row_base + ADDR_W'(SCR_W) + ADDR_W'(r_x);
          end else begin
            r_cx   <= r_cx + 10'd1;
            r_addr <= r_row_base + ADDR_W'(r_cx) + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign WRITE_EN   = r_we;
  assign WRITE_ADDR = r_addr;
  assign WRITE_DATA = r_data;
  assign REQ_DONE   = r_done;
  assign BUSY       = (r_state != S_IDLE);
  assign DBG_STATE  = r_state;

endmodule

// File: tb/tb_fb_draw_arbiter.sv
// Bench for fb_draw_arbiter: command vectors, pixel scoreboard, round-robin and reset sequences.
module tb_fb_draw_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 19;

  logic                  CLK = 1'b0;
  logic                  RST_N = 1'b0;
  logic [NUM_REQ-1:0]    REQ_VALID = '0;
  logic [NUM_REQ-1:0]    REQ_READY;
  logic [NUM_REQ*10-1:0] REQ_X = '0;
  logic [NUM_REQ*9-1:0]  REQ_Y = '0;
  logic [NUM_REQ*10-1:0] REQ_W = '0;
  logic [NUM_REQ*9-1:0]  REQ_H = '0;
  logic [NUM_REQ*24-1:0] REQ_COLOR = '0;
  logic [NUM_REQ-1:0]    REQ_DONE;
  logic                  WRITE_EN;
  logic [ADDR_W-1:0]     WRITE_ADDR;
  logic [23:0]           WRITE_DATA;
  logic                  BUSY;
  logic [1:0]            DBG_STATE;

  fb_draw_arbiter #(.NUM_REQ(NUM_REQ), .SCR_W(640), .SCR_H(480), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_X(REQ_X), .REQ_Y(REQ_Y), .REQ_W(REQ_W), .REQ_H(REQ_H), .REQ_COLOR(REQ_COLOR),
    .REQ_DONE(REQ_DONE), .WRITE_EN(WRITE_EN), .WRITE_ADDR(WRITE_ADDR),
    .WRITE_DATA(WRITE_DATA), .BUSY(BUSY), .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;
  logic [ADDR_W+24-1:0] exp_q[$];

  typedef struct {
    int          r;
    int          x, y, w, h;
    logic [23:0] c;
    int          exp_n;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: every write must match the head of the expected queue
  always @(posedge CLK) begin
    logic [ADDR_W+24-1:0] e;
    #1;
    if (WRITE_EN === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_write", longint'(WRITE_ADDR), 0);
      end else begin
        e = exp_q.pop_front();
        chk({BUSY, WRITE_ADDR, WRITE_DATA} === {1'b1, e}, "pixel",
            longint'({BUSY, WRITE_ADDR, WRITE_DATA}), longint'({1'b1, e}));
      end
    end
  end

  task automatic model_push(input int x, input int y, input int w, input int h, input logic [23:0] c);
    for (int yy = y; yy < y + h; yy++)
      for (int xx = x; xx < x + w; xx++)
        if (xx < 640 && yy < 480) exp_q.push_back({ADDR_W'(yy * 640 + xx), c});
  endtask

  task automatic set_req(input int r, input int x, input int y, input int w, input int h, input logic [23:0] c);
    REQ_X[r*10 +: 10]     = 10'(x);
    REQ_Y[r*9 +: 9]       = 9'(y);
    REQ_W[r*10 +: 10]     = 10'(w);
    REQ_H[r*9 +: 9]       = 9'(h);
    REQ_COLOR[r*24 +: 24] = c;
  endtask

  // driver: issue one command, then check write count and done latency (done = accept + 2 + N)
  task automatic run_cmd(input int r, input int x, input int y, input int w, input int h,
                         input logic [23:0] c, input int exp_n, input bit use_model);
    bit got;
    int base, k;
    if (use_model) model_push(x, y, w, h, c);
    @(negedge CLK);
    set_req(r, x, y, w, h, c);
    REQ_VALID[r] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (REQ_READY[r]) got = 1'b1;
      else @(negedge CLK);
    end
    chk(got, "ready_seen", longint'(got), 1);
    base = n_writes;
    @(posedge CLK);
    #2;
    REQ_VALID[r] = 1'b0;
    k = 0;
    got = 1'b0;
    while (!got && k < exp_n + 50) begin
      @(posedge CLK);
      #2;
      k++;
      if (REQ_DONE != '0) got = 1'b1;
    end
    chk(k == exp_n + 1, "done_latency", longint'(k), longint'(exp_n + 1));
    chk(REQ_DONE == NUM_REQ'(1) << r, "done_owner", longint'(REQ_DONE), longint'(NUM_REQ'(1) << r));
    chk(n_writes - base == exp_n, "write_count", longint'(n_writes - base), longint'(exp_n));
    @(posedge CLK);
    #2;
    chk(REQ_DONE == '0 && BUSY == 1'b0, "done_one_cycle", longint'({REQ_DONE, BUSY}), 0);
  endtask

  initial begin
    int order[5];
    int exp_order[5];
    int ng, g, base;
    bit ok;

    vecs[0] = '{1, 638, 479, 5, 4, 24'h00FF00, 2};
    vecs[1] = '{2, 0, 0, 0, 5, 24'h123456, 0};
    vecs[2] = '{3, 700, 0, 10, 1, 24'hABCDEF, 0};
    vecs[3] = '{0, 5, 478, 2, 5, 24'h0000FF, 4};
    vecs[4] = '{1, 100, 100, 4, 3, 24'(32'($urandom_range(1, 24'hFFFFFF))), 12};
    vecs[5] = '{2, 0, 480, 3, 3, 24'h777777, 0};
    vecs[6] = '{3, 639, 0, 1, 1, 24'h010203, 1};
    vecs[7] = '{0, 20, 30, 5, 0, 24'h445566, 0};
    vecs[8] = '{1, 630, 5, 20, 2, 24'h9ABCDE, 20};

    repeat (3) @(negedge CLK);
    chk({REQ_READY, REQ_DONE, WRITE_EN, WRITE_ADDR, WRITE_DATA, BUSY} == '0, "reset_state",
        longint'({REQ_DONE, WRITE_EN, WRITE_ADDR, WRITE_DATA, BUSY}), 0);
    RST_N = 1'b1;

    // worked single-command example with literal addresses
    exp_q.push_back({ADDR_W'(1290), 24'hFF0000});
    exp_q.push_back({ADDR_W'(1291), 24'hFF0000});
    exp_q.push_back({ADDR_W'(1292), 24'hFF0000});
    exp_q.push_back({ADDR_W'(1930), 24'hFF0000});
    exp_q.push_back({ADDR_W'(1931), 24'hFF0000});
    exp_q.push_back({ADDR_W'(1932), 24'hFF0000});
    run_cmd(0, 10, 2, 3, 2, 24'hFF0000, 6, 1'b0);

    foreach (vecs[i]) run_cmd(vecs[i].r, vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h,
                              vecs[i].c, vecs[i].exp_n, 1'b1);

    // large clear-style fill: consecutive addresses 0..12799
    run_cmd(2, 0, 0, 640, 20, 24'h000000, 12800, 1'b1);
    chk(exp_q.size() == 0, "queue_drained", longint'(exp_q.size()), 0);

    // reset during pixel 3 of a 4x4 fill
    @(negedge CLK);
    set_req(0, 0, 10, 4, 4, 24'h55AA55);
    REQ_VALID[0] = 1'b1;
    #1;
    chk(REQ_READY == 4'b0001, "rst_ready", longint'(REQ_READY), 1);
    for (int i = 0; i < 4; i++) exp_q.push_back({ADDR_W'(6400 + i), 24'h55AA55});
    base = n_writes;
    @(posedge CLK);
    #2;
    REQ_VALID[0] = 1'b0;
    for (int i = 0; i < 20 && (n_writes - base) < 4; i++) begin
      @(posedge CLK);
      #2;
    end
    chk(n_writes - base == 4, "rst_prefix_writes", longint'(n_writes - base), 4);
    RST_N = 1'b0;
    #1;
    chk({WRITE_EN, BUSY, REQ_DONE} == '0, "rst_async_drop", longint'({WRITE_EN, BUSY, REQ_DONE}), 0);
    ok = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      if (REQ_DONE != '0 || WRITE_EN) ok = 1'b0;
    end
    RST_N = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      if (REQ_DONE != '0 || WRITE_EN) ok = 1'b0;
    end
    chk(ok, "rst_no_done", longint'(ok), 1);
    chk(exp_q.size() == 0, "rst_queue", longint'(exp_q.size()), 0);

    // round-robin after reset: all valid, req0 holds valid for a second command
    exp_order = '{0, 1, 2, 3, 0};
    @(negedge CLK);
    for (int r = 0; r < NUM_REQ; r++) set_req(r, 10 + r, r, 1, 1, 24'(r + 1));
    REQ_VALID = '1;
    ng = 0;
    for (int cyc = 0; cyc < 100 && ng < 5; cyc++) begin
      #1;
      chk($onehot0(REQ_READY), "ready_onehot0", longint'(REQ_READY), 0);
      if (REQ_READY != '0) begin
        g = 0;
        for (int r = 0; r < NUM_REQ; r++) if (REQ_READY[r]) g = r;
        order[ng] = g;
        ng++;
        model_push(10 + g, g, 1, 1, 24'(g + 1));
        @(posedge CLK);
        #2;
        if (!(g == 0 && ng == 1)) REQ_VALID[g] = 1'b0;
      end
      @(negedge CLK);
    end
    chk(ng == 5, "rr_grants", longint'(ng), 5);
    for (int i = 0; i < 5; i++)
      if (i < ng) chk(order[i] == exp_order[i], "rr_order", longint'(order[i]), longint'(exp_order[i]));
    REQ_VALID = '0;
    for (int i = 0; i < 50 && BUSY; i++) @(negedge CLK);
    @(negedge CLK);
    chk(BUSY == 1'b0 && exp_q.size() == 0, "rr_drain", longint'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
